clk_gen_multi: RTL
==================

# clk_gen_multi

Multi-channel programmable clock/phase generator for the multicycle datapath; successor to the single fixed-ratio memory clock divider. Each of `CHANNELS` outputs produces a waveform with independently run-time-programmable high and low lengths, per-channel enable, a global phase-realignment input, and registered edge strobes for downstream sequencing. Reconfiguration is glitch-free: new lengths take effect only at a period boundary.

## Interface
- `CHANNELS`, 4: number of independent output channels (1..16).
- `CNT_W`, 4: width of length fields and per-channel counters.
- `DEF_HIGH`, 5: reset high length in cycles for every channel.
- `DEF_LOW`, 1: reset low length in cycles for every channel.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  CHANNELS  per-channel run enable, level-sensitive.
- `sync`  in  1  one-cycle pulse: realign all channels to start of LOW phase.
- `cfg_we`  in  1  config write strobe.
- `cfg_ch`  in  max(1,$clog2(CHANNELS))  target channel of write.
- `cfg_high`  in  CNT_W  new high length.
- `cfg_low`  in  CNT_W  new low length.
- `clk_out`  out  CHANNELS  generated waveforms, registered.
- `rise_stb`  out  CHANNELS  high for the first cycle `clk_out[i]` is 1.
- `fall_stb`  out  CHANNELS  high for the first cycle `clk_out[i]` is 0 after being 1.
- `cfg_pending`  out  CHANNELS  pending config not yet applied.

## Operation
- Per channel: phase bit (LOW/HIGH), counter `cnt[CNT_W]`, active `hi_len/lo_len`, pending `p_hi/p_lo` + pending flag.
- Reset (`reset`=0 at an edge): all outputs 0; phase LOW, `cnt`=0, `hi_len`=DEF_HIGH, `lo_len`=DEF_LOW, pending cleared.
- Length value 0 is treated as 1 (clamp); max length 2^CNT_W-1.
- Running (enable[i]=1): LOW phase: if `cnt==lo_len-1` then `cnt`<=0, phase<=HIGH, `clk_out`<=1, else `cnt`++. HIGH phase: if `cnt==hi_len-1` then `cnt`<=0, phase<=LOW, `clk_out`<=0, else `cnt`++. Period = hi_len+lo_len.
- Config write: `cfg_we`=1 loads `p_hi/p_lo` of `cfg_ch`, sets pending; `cfg_ch`>=CHANNELS ignored. Second write before apply overwrites pending values.
- Apply point: pending copied to active and flag cleared on the HIGH->LOW transition edge, on any `sync` edge, or on any edge while channel disabled. Write and apply on same edge: new write wins (stays pending if not applicable that edge, else applied directly).
- Disabled (enable[i]=0): `clk_out`<=0, phase LOW, `cnt`<=0. Re-enable begins a full LOW phase from `cnt`=0.
- `sync`=1: all channels forced to phase LOW, `cnt`=0, `clk_out`=0 on that edge; counting resumes next edge.
- Priority: reset > sync > disable > config apply/count.
- Strobes: `rise_stb[i]`<=1 on the edge `clk_out[i]` goes 0->1; `fall_stb[i]`<=1 on any 1->0 transition including forced by sync/disable (not reset); otherwise 0.

## Timing
- All outputs registered; no combinational input-to-output paths.
- From reset release (first edge with `reset`=1 = edge 1), default channel: `clk_out`=1 after edge DEF_LOW, =0 after edge DEF_LOW+DEF_HIGH; period 6 with defaults.
- Strobes coincide with the first cycle of the new `clk_out` level (same register update).
- Config latency: applied at next HIGH->LOW edge; next LOW phase uses new `lo_len`, following HIGH uses new `hi_len`.
- `sync`: `clk_out`=0 the cycle after; first rise lo_len edges after the sync edge.
- Reset mid-operation: all state to reset values on that edge regardless of phase or pending config.

## Test plan
- Defaults: release reset, enable=all 1 -> each `clk_out` low 1 cycle, high 5 cycles, period 6; `rise_stb` pulses every 6 cycles aligned with first high cycle.
- Reconfig mid-HIGH: ch1 write high=2,low=3 during HIGH -> `cfg_pending[1]`=1 until HIGH ends (old length 5 completes), then low 3/high 2 periodic; ch0 unaffected.
- Zero/max lengths: write high=0,low=15 -> treated high=1, low=15, period 16; out-of-range `cfg_ch` write -> no change anywhere.
- Sync while channels at different phases -> all `clk_out` 0 next cycle, `fall_stb` on those previously high, all rise together lo_len edges later.
- Disable ch2 while high -> `clk_out[2]`=0 and `fall_stb[2]`=1 next cycle; pending write applied while disabled; re-enable -> full LOW then new HIGH.
- Reset asserted mid-HIGH with pending config -> all outputs 0, pending cleared, defaults (1/5) resume after release.

Source files
------------

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock/phase generator with per-channel high/low lengths,
// enables, global realignment and registered edge strobes; new lengths apply at period end.
module clk_gen_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned DEF_HIGH = 5,
    parameter int unsigned DEF_LOW  = 1,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_low,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] rise_stb,
    output logic [CHANNELS-1:0] fall_stb,
    output logic [CHANNELS-1:0] cfg_pending
);

    localparam logic [CNT_W-1:0] DefHi = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] DefLo = CNT_W'(DEF_LOW);

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // phase_q doubles as the registered clock output (1 = HIGH phase).
    logic [CHANNELS-1:0]            phase_q, phase_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][CNT_W-1:0] hi_len_q, hi_len_d;
    logic [CHANNELS-1:0][CNT_W-1:0] lo_len_q, lo_len_d;
    logic [CHANNELS-1:0][CNT_W-1:0] p_hi_q, p_hi_d;
    logic [CHANNELS-1:0][CNT_W-1:0] p_lo_q, p_lo_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0]            rise_q, rise_d;
    logic [CHANNELS-1:0]            fall_q, fall_d;
    logic [CHANNELS-1:0]            wr, hi_end, apply;

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        hi_len_d = hi_len_q;
        lo_len_d = lo_len_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        pend_d   = pend_q;
        wr       = '0;
        hi_end   = '0;
        apply    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr[i]     = cfg_we && (32'(cfg_ch) == i);
            hi_end[i] = phase_q[i] && (cnt_q[i] == hi_len_q[i] - 1'b1);
            apply[i]  = sync || !enable[i] || hi_end[i];

            if (sync || !enable[i]) begin
                phase_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end else if (phase_q[i]) begin
                if (hi_end[i]) begin
                    phase_d[i] = 1'b0;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                if (cnt_q[i] == lo_len_q[i] - 1'b1) begin
                    phase_d[i] = 1'b1;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // A write landing on an apply edge bypasses the pending registers.
            if (apply[i]) begin
                if (wr[i]) begin
                    hi_len_d[i] = clamp(cfg_high);
                    lo_len_d[i] = clamp(cfg_low);
                end else if (pend_q[i]) begin
                    hi_len_d[i] = p_hi_q[i];
                    lo_len_d[i] = p_lo_q[i];
                end
                pend_d[i] = 1'b0;
            end else if (wr[i]) begin
                p_hi_d[i] = clamp(cfg_high);
                p_lo_d[i] = clamp(cfg_low);
                pend_d[i] = 1'b1;
            end
        end
        rise_d = phase_d & ~phase_q;
        fall_d = phase_q & ~phase_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q  <= '0;
            cnt_q    <= '0;
            hi_len_q <= {CHANNELS{DefHi}};
            lo_len_q <= {CHANNELS{DefLo}};
            p_hi_q   <= {CHANNELS{DefHi}};
            p_lo_q   <= {CHANNELS{DefLo}};
            pend_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            hi_len_q <= hi_len_d;
            lo_len_q <= lo_len_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            pend_q   <= pend_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign clk_out     = phase_q;
    assign rise_stb    = rise_q;
    assign fall_stb    = fall_q;
    assign cfg_pending = pend_q;

endmodule
